// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared opcodes, ALU codes, state encoding and control-word type
// Contents: OP_* opcode constants (IR[31:27]), ALU_* codes, ST_* state encoding,
//           instr_class_t (decoded instruction class), ctrl_t (one bit per control strobe + ALU code).
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0] ALU_ADD = 5'b00001;
    localparam logic [4:0] ALU_SUB = 5'b00010;
    localparam logic [4:0] ALU_AND = 5'b00011;
    localparam logic [4:0] ALU_OR  = 5'b00100;

    localparam logic [3:0] ST_T0   = 4'd0;
    localparam logic [3:0] ST_T1   = 4'd1;
    localparam logic [3:0] ST_T2   = 4'd2;
    localparam logic [3:0] ST_T3   = 4'd3;
    localparam logic [3:0] ST_T4   = 4'd4;
    localparam logic [3:0] ST_T5   = 4'd5;
    localparam logic [3:0] ST_T6   = 4'd6;
    localparam logic [3:0] ST_T7   = 4'd7;
    localparam logic [3:0] ST_HALT = 4'd8;

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_LD,
        CLS_LDI,
        CLS_ST,
        CLS_ALU,
        CLS_ADDI,
        CLS_BR,
        CLS_HALT
    } instr_class_t;

    typedef struct packed {
        logic       pc_out;
        logic       pc_in;
        logic       inc_pc;
        logic       mar_in;
        logic       mdr_in;
        logic       mdr_out;
        logic       mdr_read;
        logic       wren;
        logic       ir_in;
        logic       y_in;
        logic       z_in;
        logic       zlow_out;
        logic       c_out;
        logic       gra;
        logic       grb;
        logic       grc;
        logic       r_in;
        logic       r_out;
        logic       ba_out;
        logic       con_ff_in;
        logic [4:0] alu_sel;
    } ctrl_t;

endpackage

// File: rtl/opcode_decoder.sv
// rtl/opcode_decoder.sv - combinational opcode to instruction-class and ALU-code decode
// Ports: opcode (IR[31:27]) in; iclass (instr_class_t) out; alu_sel (ALU code for ALU-class ops) out.
// Macro CTRL_BRANCH_EN: when defined, opcode 10010 decodes as a branch; otherwise it is a nop.
module opcode_decoder
    import cpu_ctrl_pkg::*;
(
    input  logic [4:0]   opcode,
    output instr_class_t iclass,
    output logic [4:0]   alu_sel
);

    always_comb begin
        iclass  = CLS_NOP;
        alu_sel = ALU_ADD;
        case (opcode)
            OP_LD:   iclass = CLS_LD;
            OP_LDI:  iclass = CLS_LDI;
            OP_ST:   iclass = CLS_ST;
            OP_ADD:  begin iclass = CLS_ALU; alu_sel = ALU_ADD; end
            OP_SUB:  begin iclass = CLS_ALU; alu_sel = ALU_SUB; end
            OP_AND:  begin iclass = CLS_ALU; alu_sel = ALU_AND; end
            OP_OR:   begin iclass = CLS_ALU; alu_sel = ALU_OR;  end
            OP_ADDI: iclass = CLS_ADDI;
`ifdef CTRL_BRANCH_EN
            OP_BR:   iclass = CLS_BR;
`endif
            OP_HALT: iclass = CLS_HALT;
            default: iclass = CLS_NOP;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - T0..T7/HALT control-step sequencer for the single-bus CPU
// Ports: clk; clr (async active-low reset); IR (opcode in [31:27]); mem_ready (qualifies MDRread
//        cycles); CON (branch condition, used in T6 of a branch); datapath strobes PCout..CON_FF_In;
//        ALUSelection (ALU code); run (low only in HALT).
// Macro CTRL_BRANCH_EN: enables the branch instruction; undefined, CON_FF_In stays 0.
module control_sequencer
    import cpu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] IR,
    input  logic        mem_ready,
    input  logic        CON,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        MDRread,
    output logic        wren,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        ZLowout,
    output logic        Cout,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        CON_FF_In,
    output logic [4:0]  ALUSelection,
    output logic        run
);

    logic [3:0]   state, state_nxt;
    instr_class_t dec_cls, cls_q;
    logic [4:0]   dec_alu, alu_q;
    logic         stalled_q;
    logic         read_state;
    ctrl_t        c, o;
    logic         unused_ir;

    assign unused_ir = ^IR[26:0];

    opcode_decoder u_dec (
        .opcode  (IR[31:27]),
        .iclass  (dec_cls),
        .alu_sel (dec_alu)
    );

    assign read_state = (state == ST_T1) || (state == ST_T6 && cls_q == CLS_LD);

    always_comb begin
        state_nxt = ST_T0;
        case (state)
            ST_T0: state_nxt = ST_T1;
            ST_T1: state_nxt = mem_ready ? ST_T2 : ST_T1;
            ST_T2: state_nxt = ST_T3;
            ST_T3: begin
                case (dec_cls)
                    CLS_NOP:  state_nxt = ST_T0;
                    CLS_HALT: state_nxt = ST_HALT;
                    default:  state_nxt = ST_T4;
                endcase
            end
            ST_T4: state_nxt = ST_T5;
            ST_T5: state_nxt = (cls_q == CLS_LD || cls_q == CLS_ST || cls_q == CLS_BR) ? ST_T6 : ST_T0;
            ST_T6: begin
                if (cls_q == CLS_LD)
                    state_nxt = mem_ready ? ST_T7 : ST_T6;
                else if (cls_q == CLS_ST)
                    state_nxt = ST_T7;
                else
                    state_nxt = ST_T0;
            end
            ST_T7:   state_nxt = ST_T0;
            ST_HALT: state_nxt = ST_HALT;
            default: state_nxt = ST_T0;
        endcase
    end

    // The class is captured at T3 so later steps do not depend on IR staying stable
    // while the datapath is busy with the instruction.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state     <= ST_T0;
            cls_q     <= CLS_NOP;
            alu_q     <= ALU_ADD;
            stalled_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            stalled_q <= read_state && !mem_ready;
            if (state == ST_T3) begin
                cls_q <= dec_cls;
                alu_q <= dec_alu;
            end
        end
    end

    always_comb begin
        c         = '0;
        c.alu_sel = ALU_ADD;
        case (state)
            ST_T0: begin c.pc_out = 1'b1; c.mar_in = 1'b1; c.inc_pc = 1'b1; c.z_in = 1'b1; end
            ST_T1: begin
                // A stalled read repeats its strobes, but the PC is loaded only once.
                c.zlow_out = 1'b1; c.pc_in = !stalled_q; c.mdr_read = 1'b1; c.mdr_in = 1'b1;
            end
            ST_T2: begin c.mdr_out = 1'b1; c.ir_in = 1'b1; end
            ST_T3: begin
                case (dec_cls)
                    CLS_LD, CLS_LDI, CLS_ST: begin c.grb = 1'b1; c.ba_out = 1'b1; c.y_in = 1'b1; end
                    CLS_ALU, CLS_ADDI:       begin c.grb = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1; end
                    CLS_BR:                  begin c.gra = 1'b1; c.r_out = 1'b1; c.con_ff_in = 1'b1; end
                    default: ;
                endcase
            end
            ST_T4: begin
                case (cls_q)
                    CLS_ALU: begin c.grc = 1'b1; c.r_out = 1'b1; c.z_in = 1'b1; c.alu_sel = alu_q; end
                    CLS_BR:  begin c.pc_out = 1'b1; c.y_in = 1'b1; end
                    default: begin c.c_out = 1'b1; c.z_in = 1'b1; end
                endcase
            end
            ST_T5: begin
                case (cls_q)
                    CLS_LD, CLS_ST: begin c.zlow_out = 1'b1; c.mar_in = 1'b1; end
                    CLS_BR:         begin c.c_out = 1'b1; c.z_in = 1'b1; end
                    default:        begin c.zlow_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
                endcase
            end
            ST_T6: begin
                case (cls_q)
                    CLS_LD: begin c.mdr_read = 1'b1; c.mdr_in = 1'b1; end
                    CLS_ST: begin c.gra = 1'b1; c.r_out = 1'b1; c.mdr_in = 1'b1; end
                    CLS_BR: begin c.zlow_out = CON; c.pc_in = CON; end
                    default: ;
                endcase
            end
            ST_T7: begin
                if (cls_q == CLS_LD) begin
                    c.mdr_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1;
                end else if (cls_q == CLS_ST) begin
                    c.wren = 1'b1;
                end
            end
            default: ;
        endcase
`ifndef CTRL_BRANCH_EN
        c.con_ff_in = 1'b0;
`endif
    end

    // Reset blanks every output combinationally so strobes drop the moment clr falls.
    always_comb begin
        o = c;
        if (!clr)
            o = '0;
    end

    assign PCout        = o.pc_out;
    assign PCin         = o.pc_in;
    assign IncPC        = o.inc_pc;
    assign MARin        = o.mar_in;
    assign MDRin        = o.mdr_in;
    assign MDRout       = o.mdr_out;
    assign MDRread      = o.mdr_read;
    assign wren         = o.wren;
    assign IRin         = o.ir_in;
    assign Yin          = o.y_in;
    assign Zin          = o.z_in;
    assign ZLowout      = o.zlow_out;
    assign Cout         = o.c_out;
    assign Gra          = o.gra;
    assign Grb          = o.grb;
    assign Grc          = o.grc;
    assign Rin          = o.r_in;
    assign Rout         = o.r_out;
    assign BAout        = o.ba_out;
    assign CON_FF_In    = o.con_ff_in;
    assign ALUSelection = o.alu_sel;
    assign run          = (state != ST_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - self-checking bench for control_sequencer against a step-table model
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic [31:0] IR = '0;
    logic        mem_ready = 1'b0;
    logic        CON = 1'b0;
    logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, MDRread, wren, IRin, Yin, Zin;
    logic        ZLowout, Cout, Gra, Grb, Grc, Rin, Rout, BAout, CON_FF_In, run;
    logic [4:0]  ALUSelection;
    logic [19:0] obs;

    int checks = 0;
    int passed = 0;

    localparam logic [19:0] PCOUT = 20'd1 << 0,  PCIN = 20'd1 << 1,   INCPC = 20'd1 << 2;
    localparam logic [19:0] MARIN = 20'd1 << 3,  MDRIN = 20'd1 << 4,  MDROUT = 20'd1 << 5;
    localparam logic [19:0] MDRREAD = 20'd1 << 6, WREN = 20'd1 << 7,  IRIN = 20'd1 << 8;
    localparam logic [19:0] YIN = 20'd1 << 9,    ZIN = 20'd1 << 10,   ZLOWOUT = 20'd1 << 11;
    localparam logic [19:0] COUT = 20'd1 << 12,  GRA = 20'd1 << 13,   GRB = 20'd1 << 14;
    localparam logic [19:0] GRC = 20'd1 << 15,   RIN = 20'd1 << 16,   ROUT = 20'd1 << 17;
    localparam logic [19:0] BAOUT = 20'd1 << 18, CONFFIN = 20'd1 << 19;

    localparam logic [4:0] A_ADD = 5'd1, A_SUB = 5'd2, A_AND = 5'd3, A_OR = 5'd4;

    typedef struct {
        logic [19:0] m;
        logic [4:0]  alu;
        bit          rd;
    } step_t;

    step_t exp_q[$];

    always #5 clk = ~clk;

    assign obs = {CON_FF_In, BAout, Rout, Rin, Grc, Grb, Gra, Cout, ZLowout, Zin, Yin, IRin,
                  wren, MDRread, MDRout, MDRin, MARin, IncPC, PCin, PCout};

    control_sequencer dut (
        .clk(clk), .clr(clr), .IR(IR), .mem_ready(mem_ready), .CON(CON),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
        .MDRout(MDRout), .MDRread(MDRread), .wren(wren), .IRin(IRin), .Yin(Yin), .Zin(Zin),
        .ZLowout(ZLowout), .Cout(Cout), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin),
        .Rout(Rout), .BAout(BAout), .CON_FF_In(CON_FF_In), .ALUSelection(ALUSelection), .run(run)
    );

    function automatic void add_step(input logic [19:0] m, input logic [4:0] alu, input bit rd);
        step_t s;
        s.m = m; s.alu = alu; s.rd = rd;
        exp_q.push_back(s);
    endfunction

    // Expected control steps of one instruction, written straight from the instruction table.
    function automatic void build(input logic [4:0] op, input logic con);
        exp_q.delete();
        add_step(PCOUT | MARIN | INCPC | ZIN, A_ADD, 0);
        add_step(ZLOWOUT | PCIN | MDRREAD | MDRIN, A_ADD, 1);
        add_step(MDROUT | IRIN, A_ADD, 0);
        case (op)
            5'b00000: begin
                add_step(GRB | BAOUT | YIN, A_ADD, 0); add_step(COUT | ZIN, A_ADD, 0);
                add_step(ZLOWOUT | MARIN, A_ADD, 0); add_step(MDRREAD | MDRIN, A_ADD, 1);
                add_step(MDROUT | GRA | RIN, A_ADD, 0);
            end
            5'b00001: begin
                add_step(GRB | BAOUT | YIN, A_ADD, 0); add_step(COUT | ZIN, A_ADD, 0);
                add_step(ZLOWOUT | GRA | RIN, A_ADD, 0);
            end
            5'b00010: begin
                add_step(GRB | BAOUT | YIN, A_ADD, 0); add_step(COUT | ZIN, A_ADD, 0);
                add_step(ZLOWOUT | MARIN, A_ADD, 0); add_step(GRA | ROUT | MDRIN, A_ADD, 0);
                add_step(WREN, A_ADD, 0);
            end
            5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
                add_step(GRB | ROUT | YIN, A_ADD, 0);
                add_step(GRC | ROUT | ZIN, (op == 5'b00011) ? A_ADD : (op == 5'b00100) ? A_SUB :
                                           (op == 5'b00101) ? A_AND : A_OR, 0);
                add_step(ZLOWOUT | GRA | RIN, A_ADD, 0);
            end
            5'b01100: begin
                add_step(GRB | ROUT | YIN, A_ADD, 0); add_step(COUT | ZIN, A_ADD, 0);
                add_step(ZLOWOUT | GRA | RIN, A_ADD, 0);
            end
`ifdef CTRL_BRANCH_EN
            5'b10010: begin
                add_step(GRA | ROUT | CONFFIN, A_ADD, 0); add_step(PCOUT | YIN, A_ADD, 0);
                add_step(COUT | ZIN, A_ADD, 0); add_step(con ? (ZLOWOUT | PCIN) : 20'd0, A_ADD, 0);
            end
`endif
            default: add_step(20'd0, A_ADD, 0);
        endcase
    endfunction

    // Drives one instruction from T0 and checks every cycle. st1/st6 are stall counts for the
    // fetch read and the ld data read (-1 = random). stop_cycles >= 0 abandons the instruction
    // after that many cycles, leaving time at 1 unit past the next rising edge.
    task automatic run_instr(input logic [31:0] ir, input logic con, input int st1, input int st6,
                             input int stop_cycles, input string nm);
        int rdn = 0;
        int cyc = 0;
        int nstall;
        logic [19:0] em;
        build(ir[31:27], con);
        IR  = ir;
        CON = con;
        foreach (exp_q[i]) begin
            nstall = 0;
            if (exp_q[i].rd) begin
                nstall = (rdn == 0) ? st1 : st6;
                if (nstall < 0) nstall = $urandom_range(0, 3);
                rdn++;
            end
            for (int k = 0; k <= nstall; k++) begin
                if (stop_cycles >= 0 && cyc >= stop_cycles) return;
                mem_ready = exp_q[i].rd ? (k == nstall) : 1'($urandom_range(0, 1));
                em = exp_q[i].m;
                if (k > 0) em = em & ~PCIN;
                @(negedge clk);
                checks++;
                if ({obs, ALUSelection, run} !== {em, exp_q[i].alu, 1'b1})
                    $display("FAIL %s op=%b step=%0d stall=%0d: got strobes=%h alu=%b run=%b, want strobes=%h alu=%b run=1",
                             nm, ir[31:27], i, k, obs, ALUSelection, run, em, exp_q[i].alu);
                else
                    passed++;
                @(posedge clk); #1;
                cyc++;
            end
        end
    endtask

    task automatic check_zero(input string nm);
        checks++;
        if ({obs, ALUSelection} !== 25'd0)
            $display("FAIL %s: got strobes=%h alu=%b, want all zero", nm, obs, ALUSelection);
        else
            passed++;
    endtask

    task automatic test_reset;
        #3 check_zero("reset_hold");
        @(posedge clk); #1 check_zero("reset_after_edge");
        clr = 1'b1;
        #1;
        checks++;
        if (obs !== (PCOUT | MARIN | INCPC | ZIN) || run !== 1'b1)
            $display("FAIL reset_release_T0: got strobes=%h run=%b, want %h run=1", obs, run, PCOUT | MARIN | INCPC | ZIN);
        else
            passed++;
        run_instr({5'b11111, 27'd0}, 1'b0, 0, 0, -1, "first_nop");
    endtask

    task automatic test_st;
        run_instr(32'h10800044, 1'b0, 0, 0, -1, "st");
    endtask

    task automatic test_ld_stall;
        run_instr({5'b00000, 27'($urandom)}, 1'b0, 0, 3, -1, "ld_stall");
        run_instr({5'b00000, 27'($urandom)}, 1'b0, 2, 1, -1, "ld_fetch_stall");
    endtask

    task automatic test_alu;
        run_instr({5'b00100, 27'($urandom)}, 1'b0, 0, 0, -1, "sub");
        run_instr({5'b00101, 27'($urandom)}, 1'b0, 1, 0, -1, "and");
        run_instr({5'b00110, 27'($urandom)}, 1'b0, 0, 0, -1, "or");
        run_instr({5'b01100, 27'($urandom)}, 1'b0, 0, 0, -1, "addi");
    endtask

    task automatic test_halt;
        run_instr({5'b11011, 27'($urandom)}, 1'b0, 0, 0, -1, "halt_entry");
        for (int i = 0; i < 20; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++;
            if (obs !== 20'd0 || run !== 1'b0)
                $display("FAIL halt_hold cyc=%0d: got strobes=%h run=%b, want 0 run=0", i, obs, run);
            else
                passed++;
            @(posedge clk); #1;
        end
        clr = 1'b0;
        #1 check_zero("halt_clr");
        @(posedge clk); #1;
        clr = 1'b1;
        run_instr({5'b00001, 27'($urandom)}, 1'b0, 0, 0, -1, "after_halt_ldi");
    endtask

    task automatic test_clr_mid;
        run_instr({5'b00000, 27'($urandom)}, 1'b0, 0, 0, 5, "ld_to_T5");
        checks++;
        if (obs !== (ZLOWOUT | MARIN))
            $display("FAIL ld_T5: got strobes=%h, want %h", obs, ZLOWOUT | MARIN);
        else
            passed++;
        clr = 1'b0;
        #1 check_zero("clr_async_T5");
        @(negedge clk) check_zero("clr_hold_neg");
        @(posedge clk); #1 check_zero("clr_hold_pos");
        clr = 1'b1;
        run_instr({5'b00011, 27'($urandom)}, 1'b0, 0, 0, -1, "after_clr_add");
    endtask

    task automatic test_branch;
        run_instr({5'b10010, 27'($urandom)}, 1'b1, 0, 0, -1, "branch_con1");
        run_instr({5'b10010, 27'($urandom)}, 1'b0, 0, 0, -1, "branch_con0");
    endtask

    task automatic test_back_to_back;
        logic [4:0] op;
        for (int n = 0; n < 40; n++) begin
            op = 5'($urandom_range(0, 31));
            if (op == 5'b11011) op = 5'b00000;
            run_instr({op, 27'($urandom)}, 1'($urandom_range(0, 1)), -1, -1, -1, "random");
        end
    endtask

    initial begin
        test_reset();
        test_st();
        test_ld_stall();
        test_alu();
        test_branch();
        test_clr_mid();
        test_back_to_back();
        test_halt();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 clk  in  1  single clock; all state changes on rising edge.
REQ-002 clr  in  1  reset, asynchronous, active-low.
REQ-003 IR  in  32  current instruction; opcode = IR[31:27], IR[26:0] unused here.
REQ-004 mem_ready  in  1  memory read data valid; qualifies every MDRread cycle.
REQ-005 CON  in  1  CON_FF result (branch taken), sampled only in T6 of a branch.
REQ-006 PCout, PCin, IncPC  out  1 each  PC drive / load / increment strobes.
REQ-007 MARin, MDRin, MDRout, MDRread, wren  out  1 each  memory-path strobes; wren = memory write.
REQ-008 IRin, Yin, Zin, ZLowout, Cout  out  1 each  IR/Y/Z load, Z-low drive, C-sign-extended drive.
REQ-009 Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  register select/load/drive, base-address drive.
REQ-010 CON_FF_In  out  1  CON_FF load strobe.
REQ-011 ALUSelection  out  5  ALU operation code.
REQ-012 run  out  1  high while executing, low in HALT.

Function
REQ-013 States SHALL be T0..T7 and HALT; after reset the state is T0.
REQ-014 Exactly the strobes listed for the current state SHALL be 1; all others 0; ALUSelection = ALU_ADD unless stated.
REQ-015 Fetch: T0 PCout MARin IncPC Zin; T1 ZLowout PCin MDRread MDRin; T2 MDRout IRin; T3 decodes IR.
REQ-016 Any state driving MDRread SHALL hold (same outputs, except PCin and IncPC only on the first cycle) until mem_ready=1, then advance.
REQ-017 ld (00000): T3 Grb BAout Yin; T4 Cout Zin; T5 ZLowout MARin; T6 MDRread MDRin; T7 MDRout Gra Rin -> T0.
REQ-018 ldi (00001): T3, T4 as ld; T5 ZLowout Gra Rin -> T0.
REQ-019 st (00010): T3-T5 as ld; T6 Gra Rout MDRin; T7 wren (one cycle) -> T0.
REQ-020 add/sub/and/or (00011/00100/00101/00110): T3 Grb Rout Yin; T4 Grc Rout Zin ALUSelection=op code; T5 ZLowout Gra Rin -> T0.
REQ-021 addi (01100): T3 Grb Rout Yin; T4 Cout Zin; T5 ZLowout Gra Rin -> T0.
REQ-022 halt (11011): T3 -> HALT, run=0, all strobes 0, remain until clr.
REQ-023 Unlisted opcode: T3 asserts nothing -> T0 (nop); PC already advanced.
REQ-024 Each instruction SHALL be 6 cycles (ldi/addi/ALU) or 8 cycles (ld/st), plus mem_ready stall cycles.

Reset
REQ-025 clr=0 SHALL force T0, run=1 after release, all strobes 0, ALUSelection=0, asynchronously, including mid-instruction or in a stall.
REQ-026 The first rising clk after clr deasserts SHALL execute T0.

Configuration
REQ-027 CTRL_BRANCH_EN defined: branch (10010) supported: T3 Gra Rout CON_FF_In; T4 PCout Yin; T5 Cout Zin; T6 ZLowout PCin if CON=1, else nothing -> T0.
REQ-028 CTRL_BRANCH_EN undefined: opcode 10010 treated as nop per REQ-023; CON ignored; CON_FF_In constant 0.

Structure
REQ-029 Opcode constants, ALU_ADD=00001/ALU_SUB=00010/ALU_AND=00011/ALU_OR=00100, and the state encoding SHALL live in shared package cpu_ctrl_pkg.
REQ-030 One sub-module, opcode_decoder (IR[31:27] -> instruction class + ALU code), combinational; sequencing stays in control_sequencer.

Verification
REQ-031 IR=0x10800044 (st), mem_ready=1 -> wren high exactly in T7, Gra+Rout in T6, back to T0 eight cycles after T0.
REQ-032 ld with mem_ready low 3 cycles in T6 -> T6 outputs held 4 cycles, MDRout+Gra+Rin one cycle, total 11 cycles.
REQ-033 sub (opcode 00100) -> ALUSelection=00010 with Grc+Rout+Zin in T4, Gra+Rin in T5, 6 cycles total.
REQ-034 halt -> run=0, all strobes 0 for 20 cycles; clr pulse low -> T0 fetch resumes, run=1.
REQ-035 clr asserted in T5 of ld -> outputs 0 immediately, no Rin pulse, next cycle after release is T0.
REQ-036 With CTRL_BRANCH_EN: branch CON=1 -> PCin in T6; CON=0 -> no PCin; without macro -> 4-cycle nop.
